// File: rtl/fp_pkg.sv
// Shared FPU constants, field/class payloads and converter state encoding.
package fp_pkg;

  localparam int unsigned FP_W      = 32;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned FP_MANT_W = FP_FRAC_W + 1;
  localparam int unsigned FP_BIAS   = 127;
  localparam int unsigned INT_W     = 32;
  localparam int unsigned CNT_W     = 5;

  localparam logic [7:0]       FP_EXP_MAX  = 8'hFF;
  localparam logic [INT_W-1:0] INT_MAX     = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN     = 32'h8000_0000;
  localparam logic [FP_W-1:0]  FP_NEG_2_31 = 32'hCF00_0000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } ftoi_state_t;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_MANT_W-1:0] mant;
  } fp_fields_t;

  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic nan;
  } fp_class_t;

endpackage

// File: rtl/float_to_int_if.sv
// Operand/result handshake bundle between the FP register file side and integer writeback.
interface float_to_int_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_fp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_int;
  logic        out_invalid;
  logic        out_inexact;

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_int, out_invalid, out_inexact
  );

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_int, out_invalid, out_inexact
  );

endinterface

// File: rtl/fp_unpack.sv
// Combinational split of an IEEE-754 single into fields plus zero/denorm/inf/nan class.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] fp,
  output fp_fields_t      fields,
  output fp_class_t       cls
);

  logic exp_zero;
  logic exp_max;
  logic frac_zero;

  assign exp_zero  = (fp[30:23] == 8'h00);
  assign exp_max   = (fp[30:23] == FP_EXP_MAX);
  assign frac_zero = (fp[FP_FRAC_W-1:0] == '0);

  assign fields = {fp[31], fp[30:23], ~exp_zero, fp[FP_FRAC_W-1:0]};
  assign cls    = {exp_zero & frac_zero, exp_zero & ~frac_zero,
                   exp_max & frac_zero, exp_max & ~frac_zero};

endmodule

// File: rtl/float_to_int.sv
// Multi-cycle single-precision to int32 converter; iterative significand shifter.
// Build option FTOI_ROUND_NEAREST_EN: round to nearest-even instead of truncating.
module float_to_int
  import fp_pkg::*;
#(
  parameter int unsigned SHIFT_PER_CYCLE = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  float_to_int_if.slave  io
);

  localparam int unsigned      RND_W = INT_W + 1;
  localparam logic [CNT_W-1:0] STEP  = CNT_W'(SHIFT_PER_CYCLE);

  ftoi_state_t      state_q, state_n;
  logic             sign_q, sign_n, inv_q, inv_n, left_q, left_n;
  logic             guard_q, guard_n, sticky_q, sticky_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [INT_W-1:0] mag_q, mag_n, out_int_q, out_int_n;
  logic             in_ready_q, in_ready_n, out_valid_q, out_valid_n;
  logic             out_invalid_q, out_invalid_n, out_inexact_q, out_inexact_n;

  fp_fields_t       fields;
  fp_class_t        cls;
  logic signed [8:0] exp_unb;
  logic [CNT_W-1:0] step;
  logic [INT_W-1:0] low_mask;
  logic [RND_W-1:0] rnd;

  fp_unpack u_unpack (.fp(io.in_fp), .fields(fields), .cls(cls));

  assign exp_unb  = $signed({1'b0, fields.exp}) - $signed(9'(FP_BIAS));
  assign step     = (cnt_q < STEP) ? cnt_q : STEP;
  // Bits below the new guard position, which fold into sticky on a right shift.
  assign low_mask = (INT_W'(1) << (step - CNT_W'(1))) - INT_W'(1);

`ifdef FTOI_ROUND_NEAREST_EN
  assign rnd = {1'b0, mag_q} + RND_W'(guard_q & (sticky_q | mag_q[0]));
`else
  assign rnd = {1'b0, mag_q};
`endif

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.out_int     = out_int_q;
  assign io.out_invalid = out_invalid_q;
  assign io.out_inexact = out_inexact_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      inv_q         <= 1'b0;
      left_q        <= 1'b0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      mag_q         <= '0;
      out_int_q     <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_invalid_q <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      sign_q        <= sign_n;
      inv_q         <= inv_n;
      left_q        <= left_n;
      guard_q       <= guard_n;
      sticky_q      <= sticky_n;
      cnt_q         <= cnt_n;
      mag_q         <= mag_n;
      out_int_q     <= out_int_n;
      in_ready_q    <= in_ready_n;
      out_valid_q   <= out_valid_n;
      out_invalid_q <= out_invalid_n;
      out_inexact_q <= out_inexact_n;
    end
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_n       = state_q;
    sign_n        = sign_q;
    inv_n         = inv_q;
    left_n        = left_q;
    guard_n       = guard_q;
    sticky_n      = sticky_q;
    cnt_n         = cnt_q;
    mag_n         = mag_q;
    out_int_n     = out_int_q;
    in_ready_n    = in_ready_q;
    out_valid_n   = out_valid_q;
    out_invalid_n = out_invalid_q;
    out_inexact_n = out_inexact_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          sign_n     = fields.sign;
          inv_n      = 1'b0;
          left_n     = 1'b0;
          guard_n    = 1'b0;
          sticky_n   = 1'b0;
          cnt_n      = '0;
          mag_n      = {8'h00, fields.mant};
          in_ready_n = 1'b0;
          state_n    = SHIFT;
          if (cls.nan || cls.inf) begin
            inv_n = 1'b1;
            mag_n = '0;
          end else if (exp_unb >= 9'sd31) begin
            // -2^31 is the only representable operand at or beyond 2^31.
            if (io.in_fp == FP_NEG_2_31) begin
              mag_n = INT_MIN;
            end else begin
              inv_n = 1'b1;
              mag_n = '0;
            end
          end else if (cls.zero || cls.denorm || (exp_unb < 9'sd0)) begin
            mag_n    = '0;
            sticky_n = ~cls.zero;
`ifdef FTOI_ROUND_NEAREST_EN
            if (exp_unb == -9'sd1) begin
              guard_n  = 1'b1;
              sticky_n = |fields.mant[FP_FRAC_W-1:0];
            end
`endif
          end else if (exp_unb <= 9'sd22) begin
            cnt_n = CNT_W'(9'd23 - $unsigned(exp_unb));
          end else begin
            left_n = 1'b1;
            cnt_n  = CNT_W'($unsigned(exp_unb) - 9'd23);
          end
        end
      end

      SHIFT: begin
        if (cnt_q == '0) begin
          state_n = SIGN;
        end else begin
          cnt_n = cnt_q - step;
          if (left_q) begin
            mag_n = mag_q << step;
          end else begin
            mag_n    = mag_q >> step;
            guard_n  = mag_q[step - CNT_W'(1)];
            sticky_n = sticky_q | guard_q | (|(mag_q & low_mask));
          end
        end
      end

      SIGN: begin
        out_inexact_n = guard_q | sticky_q;
        out_invalid_n = 1'b0;
        if (inv_q) begin
          out_int_n     = INT_MAX;
          out_invalid_n = 1'b1;
        end else if (rnd[RND_W-1:RND_W-2] != 2'b00) begin
          if (sign_q && (rnd == {1'b0, INT_MIN})) begin
            out_int_n = INT_MIN;
          end else begin
            out_int_n     = INT_MAX;
            out_invalid_n = 1'b1;
          end
        end else begin
          out_int_n = sign_q ? (~rnd[INT_W-1:0] + INT_W'(1)) : rnd[INT_W-1:0];
        end
        out_valid_n = 1'b1;
        state_n     = DONE;
      end

      DONE: begin
        if (io.out_ready) begin
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle IEEE-754 single-precision to signed 32-bit integer converter (MIPS trunc.w.s / cvt.w.s path).
- Decodes sign, exponent and fraction in the opposite direction to the FPU's float packing, then shifts the 24-bit significand iteratively into integer position.
- Sits between the FP register file and the integer writeback path; valid/ready handshake on both sides.

Parameters:
- SHIFT_PER_CYCLE, 1, significand bits shifted per cycle in SHIFT state; legal range 1..8.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand valid.
- IN_READY  output  1  converter can accept an operand.
- IN_FP  input  32  IEEE-754 single operand.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- OUT_INT  output  32  two's-complement result.
- OUT_INVALID  output  1  NaN, infinity or out-of-range operand.
- OUT_INEXACT  output  1  nonzero bits were discarded.

Behaviour:
- Reset (async, RST_N=0): state IDLE; IN_READY=1; OUT_VALID=0; OUT_INT=0; OUT_INVALID=0; OUT_INEXACT=0; all internal registers cleared. Reset mid-conversion discards the operation; no result is produced.
- States: IDLE, SHIFT, SIGN, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID, capture sign s, exponent E, mantissa M={E!=0,frac} (24 bits), and e=E-127 (signed 9-bit). Go to SHIFT.
- Capture classification:
  - E==255: invalid. Result 0x7FFFFFFF; shift count 0.
  - e>=31, except IN_FP==0xCF000000: invalid, 0x7FFFFFFF. Exactly 0xCF000000 gives 0x80000000 with no flags.
  - e<0 (includes zero and denormals): magnitude 0; inexact = (IN_FP[30:0]!=0); shift count 0.
  - 0<=e<=22: right shift by 23-e.
  - 23<=e<=30: left shift by e-23.
- SHIFT:
  - Each cycle shift the magnitude by min(SHIFT_PER_CYCLE, remaining) and decrement the count.
  - On right shifts, OR shifted-out bits into a sticky register. Separately track the guard bit (last bit shifted out).
  - At count 0, go to SIGN. A shift count of 0 still spends 1 cycle in SHIFT.
- SIGN: apply two's complement if s=1 and not invalid. Latch OUT_INT and flags, and set OUT_INEXACT=(guard|sticky). Go to DONE.
- DONE:
  - OUT_VALID=1 and IN_READY=0.
  - OUT_INT and flags hold stable until OUT_READY. On OUT_VALID&OUT_READY, go to IDLE.
- Latency from accept to OUT_VALID: ceil(n/SHIFT_PER_CYCLE)+2 cycles, where n is the shift amount.
- No new operand is accepted before the handshake completes, so throughput is one conversion in flight.
- Negative zero gives 0x00000000. NaN payload and sign are ignored.
- Magnitude register is 32 bits; left shifts never exceed 7, so there is no overflow inside the datapath.

Optional Feature:
- Macro FTOI_ROUND_NEAREST_EN.
- Defined: SIGN state rounds to nearest-even before negation. Increment magnitude when guard & (sticky | lsb). If rounding carries the result to 2^31, flag invalid and return 0x7FFFFFFF (0x80000000 if s=1 and magnitude==2^31 exactly). e==-1 (values in [0.5,1)) uses guard=1 and sticky=(frac!=0).
- Undefined: truncate toward zero only; the rounding incrementer is absent.

Decomposition:
- Shared package fp_pkg:
  - constants FP_BIAS=127, FP_EXP_MAX=8'hFF, FP_FRAC_W=23, INT_MAX=32'h7FFFFFFF, INT_MIN=32'h80000000.
  - state enum typedef ftoi_state_t.
- One sub-module: fp_unpack (combinational). Splits IN_FP into sign/exponent/mantissa and produces class flags (zero, denorm, inf, nan). It can be reused by later FPU blocks.

Test Plan:
- 0x40490FDB (3.14159), OUT_READY=1: OUT_INT=3, INEXACT=1, INVALID=0. OUT_VALID 24 cycles after accept at SHIFT_PER_CYCLE=1; 5 cycles at 8.
- 0xC2F60000 (-123.0): OUT_INT=0xFFFFFF85, INEXACT=0, INVALID=0.
- 0x4F000000 → 0x7FFFFFFF with INVALID=1. 0xCF000000 → 0x80000000 with INVALID=0. 0x7FC00000 (NaN) and 0xFF800000 (-inf) → 0x7FFFFFFF with INVALID=1.
- 0x3FC00000 (1.5) → 1 with INEXACT=1 (truncate); 2 with FTOI_ROUND_NEAREST_EN. 0x3F000000 (0.5) → 0 with INEXACT=1 in both builds.
- Backpressure: hold OUT_READY=0 for 10 cycles. OUT_INT stays stable, IN_READY=0, and a second IN_VALID is not accepted. The second operand is accepted the cycle after the handshake.
- Assert RST_N=0 mid-SHIFT on 0x40490FDB: outputs return to reset values immediately and no OUT_VALID pulse appears. The next operand converts correctly.
